// File: rtl/riscv_busc_pkg.sv
// Shared types and helpers for the handshaked bus crossbar select/response block.
package riscv_busc_pkg;

    typedef enum logic {
        BUSC_IDLE,
        BUSC_RESP
    } busc_state_e;

    // Width of the slave-index field; a single slave still needs one bit.
    function automatic int unsigned sel_w(input int unsigned nslaves);
        return (nslaves <= 2) ? 1 : $clog2(nslaves);
    endfunction

endpackage

// File: rtl/riscv_busc_dec.sv
// Combinational slave decoder: address index field to one-hot select and decode error.
module riscv_busc_dec
    import riscv_busc_pkg::*;
#(
    parameter int unsigned NSLAVES = 4,
    localparam int unsigned SEL_W  = sel_w(NSLAVES)
) (
    input  logic [SEL_W-1:0]   field,
    output logic [SEL_W-1:0]   idx,
    output logic [NSLAVES-1:0] sel,
    output logic               decode_err
);

    assign idx        = field;
    assign decode_err = (32'(field) >= NSLAVES);

    always_comb begin
        sel = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            sel[i] = !decode_err && (field == SEL_W'(i));
        end
    end

endmodule

// File: rtl/riscv_busc_hs.sv
// Handshaked slave select and response mux: one outstanding transaction, registered
// response, decode-error and timeout error responses.
module riscv_busc_hs
    import riscv_busc_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned NSLAVES       = 4,
    parameter int unsigned SLV_START_IDX = 28,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m_req_i,
    input  logic                m_we_i,
    input  logic [XLEN-1:0]     m_addr_i,
    input  logic [XLEN-1:0]     m_wdata_i,
    input  logic [XLEN/8-1:0]   m_be_i,
    output logic                m_gnt_o,
    output logic                m_rvalid_o,
    output logic [XLEN-1:0]     m_rdata_o,
    output logic                m_err_o,
    output logic [NSLAVES-1:0]  s_req_o,
    output logic                s_we_o,
    output logic [XLEN-1:0]     s_addr_o,
    output logic [XLEN-1:0]     s_wdata_o,
    output logic [XLEN/8-1:0]   s_be_o,
    input  logic [NSLAVES-1:0]  s_gnt_i,
    input  logic [NSLAVES-1:0]  s_rvalid_i,
    input  logic [XLEN-1:0]     s_rdata_i [0:NSLAVES-1]
);

    localparam int unsigned SEL_W = sel_w(NSLAVES);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    busc_state_e        state;
    logic [CNT_W-1:0]   cnt;
    logic [SEL_W-1:0]   owner;

    logic [SEL_W-1:0]   idx;
    logic [NSLAVES-1:0] sel;
    logic               decode_err;
    logic               slave_gnt;
    logic               owner_rvalid;
    logic [XLEN-1:0]    owner_rdata;

    riscv_busc_dec #(
        .NSLAVES (NSLAVES)
    ) u_dec (
        .field      (m_addr_i[SLV_START_IDX +: SEL_W]),
        .idx        (idx),
        .sel        (sel),
        .decode_err (decode_err)
    );

    assign slave_gnt = |(s_gnt_i & sel);

    assign s_req_o = (state == BUSC_IDLE && m_req_i) ? sel : '0;
    assign m_gnt_o = (state == BUSC_IDLE) && m_req_i && (decode_err || slave_gnt);

    assign s_we_o    = m_we_i;
    assign s_addr_o  = m_addr_i;
    assign s_wdata_o = m_wdata_i;
    assign s_be_o    = m_be_i;

    // Only the owning slave's response is observed; everyone else is ignored.
    always_comb begin
        owner_rvalid = 1'b0;
        owner_rdata  = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (owner == SEL_W'(i)) begin
                owner_rvalid = s_rvalid_i[i];
                owner_rdata  = s_rdata_i[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BUSC_IDLE;
            cnt        <= '0;
            owner      <= '0;
            m_rvalid_o <= 1'b0;
            m_err_o    <= 1'b0;
            m_rdata_o  <= '0;
        end else begin
            m_rvalid_o <= 1'b0;
            m_err_o    <= 1'b0;
            m_rdata_o  <= '0;
            case (state)
                BUSC_IDLE: begin
                    if (m_req_i && decode_err) begin
                        m_rvalid_o <= 1'b1;
                        m_err_o    <= 1'b1;
                    end else if (m_req_i && slave_gnt) begin
                        owner <= idx;
                        cnt   <= '0;
                        state <= BUSC_RESP;
                    end
                end
                BUSC_RESP: begin
                    // A response arriving on the last wait cycle beats the timeout.
                    if (owner_rvalid) begin
                        m_rvalid_o <= 1'b1;
                        m_rdata_o  <= owner_rdata;
                        state      <= BUSC_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        m_rvalid_o <= 1'b1;
                        m_err_o    <= 1'b1;
                        state      <= BUSC_IDLE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= BUSC_IDLE;
            endcase
        end
    end

endmodule
